// File: rtl/freq_div_pkg.sv
// Shared types and constants for the divider / BCD counter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package freq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/pulse_bcd_counter_digit.sv
// One BCD decade: counts 0..9 on inc, ripples a carry out when leaving 9.
// Latency: q updates one clk after inc/clr; carry is combinational from inc.
// Backpressure: none; every inc is consumed in the cycle it is presented.
module bcd_digit
    import freq_div_pkg::*;
(
    input  logic             clk,
    input  logic             nRst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] r_q;
    logic             w_at_max;

    assign w_at_max = (r_q == BCD_MAX);
    assign carry    = inc & w_at_max;
    assign q        = r_q;

    // Decade register: clear wins, 9 rolls to 0, otherwise step by one.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= w_at_max ? '0 : r_q + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_bcd_counter.sv
// N-decade BCD event counter with button start/stop toggle and sync clear.
// Latency: pulse->digits 1 clk; button->running SYNC_STAGES clk after first sample; clear 1 clk.
// Backpressure: none; back-to-back pulses are all counted while running.
module pulse_bcd_counter
    import freq_div_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      pulse,
    input  logic                      start_stop,
    input  logic                      clear,
    output logic [BCD_W*N_DIGITS-1:0] digits,
    output logic                      running,
    output logic                      wrap
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_ss_edge;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_running;
    logic                   r_wrap;

    logic                   w_inc;
    logic [N_DIGITS:0]      w_carry;

    // Button synchronizer chain plus one history flop for rising-edge detect.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], start_stop};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // A held button yields exactly one edge because history follows the sync output.
    assign w_ss_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

    // Next-state logic: clear overrides everything, otherwise the button toggles.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_ss_edge) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_RUN;
                ST_RUN:  w_state_nxt = ST_HOLD;
                ST_HOLD: w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register; running is registered from the next state so it has no input path.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    // The increment uses the current state, so a pulse coinciding with the stop edge still counts.
    // Gating with clear keeps the final carry (and hence wrap) low during a clear.
    assign w_inc      = (r_state == ST_RUN) & pulse & ~clear;
    assign w_carry[0] = w_inc;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .nRst  (nRst),
            .clr   (clear),
            .inc   (w_carry[g]),
            .q     (digits[g*BCD_W +: BCD_W]),
            .carry (w_carry[g+1])
        );
    end

    // Wrap strobe: the carry out of the top decade, registered to align with the all-zero digits.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[N_DIGITS];
        end
    end

    assign running = r_running;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_pulse_bcd_counter.sv
module tb_pulse_bcd_counter;

    logic        clk        = 1'b0;
    logic        nRst       = 1'b0;
    logic        pulse      = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear      = 1'b0;

    logic [15:0] digits4;
    logic        running4;
    logic        wrap4;
    logic [3:0]  digits1;
    logic        running1;
    logic        wrap1;

    always #5 clk = ~clk;

    pulse_bcd_counter #(.N_DIGITS(4), .SYNC_STAGES(2)) u_dut4 (
        .clk        (clk),
        .nRst       (nRst),
        .pulse      (pulse),
        .start_stop (start_stop),
        .clear      (clear),
        .digits     (digits4),
        .running    (running4),
        .wrap       (wrap4)
    );

    pulse_bcd_counter #(.N_DIGITS(1), .SYNC_STAGES(2)) u_dut1 (
        .clk        (clk),
        .nRst       (nRst),
        .pulse      (pulse),
        .start_stop (start_stop),
        .clear      (clear),
        .digits     (digits1),
        .running    (running1),
        .wrap       (wrap1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int value, input int ndig);
        logic [31:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < ndig; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference model: integer count modulo 10^N, abstract run/hold/idle mode,
    // button rising edge seen at a sampling edge takes effect two edges later.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    int m_cnt4    = 0;
    int m_cnt1    = 0;
    int m_state   = M_IDLE;
    bit m_wrap4   = 0;
    bit m_wrap1   = 0;
    bit m_prev_ss = 0;
    bit m_d1      = 0;
    bit m_d2      = 0;
    bit m_tg      = 0;
    bit m_inc     = 0;

    initial forever begin
        @(posedge clk or negedge nRst);
        if (!nRst) begin
            m_cnt4 = 0; m_cnt1 = 0; m_state = M_IDLE;
            m_wrap4 = 0; m_wrap1 = 0;
            m_prev_ss = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            m_tg      = m_d2;
            m_d2      = m_d1;
            m_d1      = start_stop && !m_prev_ss;
            m_prev_ss = start_stop;
            if (clear) begin
                m_cnt4 = 0; m_cnt1 = 0; m_state = M_IDLE;
                m_wrap4 = 0; m_wrap1 = 0;
            end else begin
                m_inc   = (m_state == M_RUN) && pulse;
                m_wrap4 = m_inc && (m_cnt4 == 9999);
                m_wrap1 = m_inc && (m_cnt1 == 9);
                if (m_inc) begin
                    m_cnt4 = (m_cnt4 + 1) % 10000;
                    m_cnt1 = (m_cnt1 + 1) % 10;
                end
                if (m_tg) m_state = (m_state == M_RUN) ? M_HOLD : M_RUN;
            end
        end
    end

    bit chk_en = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check_val("mdl_digits4",  digits4,  to_bcd(m_cnt4, 4));
            check_val("mdl_running4", running4, m_state == M_RUN);
            check_val("mdl_wrap4",    wrap4,    m_wrap4);
            check_val("mdl_digits1",  digits1,  to_bcd(m_cnt1, 1));
            check_val("mdl_running1", running1, m_state == M_RUN);
            check_val("mdl_wrap1",    wrap1,    m_wrap1);
        end
    end

    task automatic pulses(input int n);
        repeat (n) begin
            pulse = 1'b1;
            @(negedge clk);
            pulse = 1'b0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic press();
        start_stop = 1'b1;
        repeat (3) @(negedge clk);
        start_stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic restart();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        press();
    endtask

    int  toggles;
    logic prev_run;

    initial begin
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        check_val("rst_digits",  digits4,  32'h0);
        check_val("rst_running", running4, 32'h0);
        check_val("rst_wrap",    wrap4,    32'h0);
        nRst = 1'b1;
        @(negedge clk);

        // Pulses while idle are ignored
        pulse = 1'b1;
        repeat (5) @(negedge clk);
        pulse = 1'b0;
        check_val("idle_pulse", digits4, 32'h0);

        // Start latency: first sampled at edge k, running after k+2
        start_stop = 1'b1;
        @(negedge clk);
        check_val("ss_after_k",  running4, 32'h0);
        @(negedge clk);
        check_val("ss_after_k1", running4, 32'h0);
        @(negedge clk);
        check_val("ss_after_k2", running4, 32'h1);
        start_stop = 1'b0;
        @(negedge clk);

        pulses(37);
        check_val("count37", digits4, 32'h0037);

        // Clear latency
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_val("clr_digits",  digits4,  32'h0);
        check_val("clr_running", running4, 32'h0);

        // Hold with a pulse coincident with the stop edge
        press();
        pulses(9);
        check_val("pre_hold4", digits4, 32'h0009);
        check_val("pre_hold1", digits1, 32'h9);
        start_stop = 1'b1;
        repeat (2) @(negedge clk);
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        start_stop = 1'b0;
        check_val("hold_digits4", digits4,  32'h0010);
        check_val("hold_running", running4, 32'h0);
        check_val("hold_wrap4",   wrap4,    32'h0);
        check_val("n1_digits",    digits1,  32'h0);
        check_val("n1_wrap",      wrap1,    32'h1);
        @(negedge clk);
        check_val("n1_wrap_end",  wrap1,    32'h0);
        pulses(5);
        check_val("hold_ignore",  digits4,  32'h0010);
        press();
        check_val("resume", running4, 32'h1);

        // Rollover from 9999
        restart();
        pulse = 1'b1;
        repeat (9999) @(negedge clk);
        pulse = 1'b0;
        check_val("at_9999", digits4, 32'h9999);
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        check_val("roll_digits",  digits4,  32'h0);
        check_val("roll_wrap",    wrap4,    32'h1);
        check_val("roll_running", running4, 32'h1);
        @(negedge clk);
        check_val("roll_wrap_end", wrap4, 32'h0);

        // Clear beats pulse and button edge together
        restart();
        pulses(456);
        check_val("at_456", digits4, 32'h0456);
        start_stop = 1'b1;
        repeat (2) @(negedge clk);
        pulse = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        clear = 1'b0;
        start_stop = 1'b0;
        check_val("prio_digits",  digits4,  32'h0);
        check_val("prio_running", running4, 32'h0);
        check_val("prio_wrap",    wrap4,    32'h0);
        repeat (3) @(negedge clk);
        check_val("prio_idle", running4, 32'h0);

        // Button held for 100 cycles toggles once
        toggles = 0;
        prev_run = running4;
        start_stop = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (running4 != prev_run) toggles++;
            prev_run = running4;
        end
        start_stop = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (running4 != prev_run) toggles++;
            prev_run = running4;
        end
        check_val("held_toggles", toggles,  32'd1);
        check_val("held_running", running4, 32'h1);

        // Asynchronous reset mid-count
        restart();
        pulses(123);
        check_val("at_123", digits4, 32'h0123);
        @(posedge clk);
        #2 nRst = 1'b0;
        #1;
        check_val("arst_digits4",  digits4,  32'h0);
        check_val("arst_running4", running4, 32'h0);
        check_val("arst_wrap4",    wrap4,    32'h0);
        check_val("arst_digits1",  digits1,  32'h0);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        // Random traffic against the model
        repeat (3000) begin
            @(negedge clk);
            pulse = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) start_stop = ~start_stop;
        end
        pulse = 1'b0;
        clear = 1'b0;
        start_stop = 1'b0;
        @(negedge clk);
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
